sisc_seq: RTL and testbench

Multi-cycle control sequencer for the SISC datapath. It steps each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK, and drives the per-state enables and selects of the PC, instruction register, register file, ALU, status register and data memory. Branch conditions are resolved against the status flags. The block sits beside the datapath in the `sisc` top level, reads the instruction register output and `stat`, and owns every write enable in the core.

---
 rtl/sisc_seq.sv | 118 +++++++++++
 tb/tb_sisc_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sisc_seq.sv
// sisc_seq: multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK control sequencer for the SISC datapath.
// Owns every write enable in the core and resolves branches against the status flags.
module sisc_seq #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_f,
    input  logic [31:0]      ir,
    input  logic [3:0]       stat,
    output logic             pc_rst,
    output logic             pc_write,
    output logic             pc_sel,
    output logic             br_sel,
    output logic             ir_load,
    output logic             rf_we,
    output logic [1:0]       alu_op,
    output logic             stat_en,
    output logic             wb_sel,
    output logic             rb_sel,
    output logic             dm_we,
    output logic             halted,
    output logic [CNT_W-1:0] instr_cnt
);
    typedef enum logic [2:0] {
        START0, START1, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT
    } state_t;

    localparam logic [3:0] OP_RR  = 4'b0001;
    localparam logic [3:0] OP_RI  = 4'b0010;
    localparam logic [3:0] OP_LD  = 4'b1000;
    localparam logic [3:0] OP_ST  = 4'b1001;
    localparam logic [3:0] OP_HLT = 4'b1111;

    state_t           r_state;
    state_t           w_next;
    logic [7:0]       r_opmm;
    logic [CNT_W-1:0] r_cnt;

    logic [3:0] w_op;
    logic [3:0] w_mm;
    logic       w_is_alu;
    logic       w_is_mem;
    logic       w_hit;
    logic       w_taken;
    logic       w_retire;
    logic [1:0] w_alu_op;
    logic       w_fetch;
    logic       w_exec;
    logic       w_mem;
    logic       w_wb;
    logic       w_unused_ir;

    assign w_op     = r_opmm[7:4];
    assign w_mm     = r_opmm[3:0];
    assign w_is_alu = (w_op == OP_RR) || (w_op == OP_RI);
    assign w_is_mem = (w_op == OP_LD) || (w_op == OP_ST);
    assign w_hit    = |(w_mm & stat);
    // 010x branch on any selected flag set (mm=0 always), 011x branch when all selected flags clear
    assign w_taken  = (w_op[3:1] == 3'b010) ? ((w_mm == 4'b0000) || w_hit) :
                      (w_op[3:1] == 3'b011) ? !w_hit : 1'b0;
    assign w_unused_ir = ^ir[23:0];

    always_comb begin
        w_next = r_state;
        case (r_state)
            START0:    w_next = START1;
            START1:    w_next = FETCH;
            FETCH:     w_next = DECODE;
            DECODE:    w_next = (ir[31:28] == OP_HLT) ? HALT : EXECUTE;
            EXECUTE:   w_next = w_is_mem ? MEM : w_is_alu ? WRITEBACK : FETCH;
            MEM:       w_next = (w_op == OP_LD) ? WRITEBACK : FETCH;
            WRITEBACK: w_next = FETCH;
            HALT:      w_next = HALT;
            default:   w_next = START0;
        endcase
    end

    assign w_retire = ((w_next == FETCH) &&
                       (r_state == EXECUTE || r_state == MEM || r_state == WRITEBACK)) ||
                      ((r_state == DECODE) && (w_next == HALT));

    always_ff @(posedge clk) begin
        if (!rst_f) begin
            r_state <= START0;
            r_opmm  <= 8'h00;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == DECODE && w_next == EXECUTE)
                r_opmm <= ir[31:24];
            if (w_retire)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_fetch  = (r_state == FETCH);
    assign w_exec   = (r_state == EXECUTE);
    assign w_mem    = (r_state == MEM);
    assign w_wb     = (r_state == WRITEBACK);
    assign w_alu_op = (w_op == OP_RR) ? 2'b01 :
                      (w_op == OP_RI) ? 2'b11 :
                      w_is_mem        ? 2'b10 : 2'b00;

    // write enables are held low combinationally for as long as reset is asserted
    assign pc_rst    = (r_state == START0);
    assign pc_write  = rst_f && (w_fetch || (w_exec && w_taken));
    assign pc_sel    = w_exec && w_taken;
    assign br_sel    = w_exec && w_taken && w_op[0];
    assign ir_load   = rst_f && w_fetch;
    assign rf_we     = rst_f && w_wb;
    assign alu_op    = (w_exec || w_wb) ? w_alu_op : 2'b00;
    assign stat_en   = rst_f && w_exec && w_is_alu;
    assign wb_sel    = w_wb && (w_op == OP_LD);
    assign rb_sel    = (w_exec || w_mem) && (w_op == OP_ST);
    assign dm_we     = rst_f && w_mem && (w_op == OP_ST);
    assign halted    = (r_state == HALT);
    assign instr_cnt = r_cnt;
endmodule

// File: tb/tb_sisc_seq.sv
// tb_sisc_seq: directed self-checking bench for sisc_seq.
// Outputs are packed {pc_rst,pc_write,pc_sel,br_sel,ir_load,rf_we,alu_op,stat_en,wb_sel,rb_sel,dm_we,halted}.
module tb_sisc_seq;
    logic        clk = 1'b0;
    logic        rst_f;
    logic [31:0] ir;
    logic [3:0]  stat;

    logic        pc_rst, pc_write, pc_sel, br_sel, ir_load, rf_we, stat_en, wb_sel, rb_sel, dm_we, halted;
    logic [1:0]  alu_op;
    logic [15:0] instr_cnt;
    logic        pc_rst2, pc_write2, pc_sel2, br_sel2, ir_load2, rf_we2, stat_en2, wb_sel2, rb_sel2, dm_we2, halted2;
    logic [1:0]  alu_op2;
    logic [1:0]  instr_cnt2;

    logic [12:0] w_out, w_out2;
    logic [12:0] obs [0:7];
    int checks = 0;
    int errors = 0;

    sisc_seq #(.CNT_W(16)) dut (
        .clk(clk), .rst_f(rst_f), .ir(ir), .stat(stat),
        .pc_rst(pc_rst), .pc_write(pc_write), .pc_sel(pc_sel), .br_sel(br_sel),
        .ir_load(ir_load), .rf_we(rf_we), .alu_op(alu_op), .stat_en(stat_en),
        .wb_sel(wb_sel), .rb_sel(rb_sel), .dm_we(dm_we), .halted(halted),
        .instr_cnt(instr_cnt)
    );

    sisc_seq #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_f(rst_f), .ir(ir), .stat(stat),
        .pc_rst(pc_rst2), .pc_write(pc_write2), .pc_sel(pc_sel2), .br_sel(br_sel2),
        .ir_load(ir_load2), .rf_we(rf_we2), .alu_op(alu_op2), .stat_en(stat_en2),
        .wb_sel(wb_sel2), .rb_sel(rb_sel2), .dm_we(dm_we2), .halted(halted2),
        .instr_cnt(instr_cnt2)
    );

    assign w_out  = {pc_rst, pc_write, pc_sel, br_sel, ir_load, rf_we, alu_op,
                     stat_en, wb_sel, rb_sel, dm_we, halted};
    assign w_out2 = {pc_rst2, pc_write2, pc_sel2, br_sel2, ir_load2, rf_we2, alu_op2,
                     stat_en2, wb_sel2, rb_sel2, dm_we2, halted2};

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in FETCH; records outputs for n cycles plus the state that follows.
    // ir is scrambled once EXECUTE starts so that only the latched opcode can be used.
    task automatic run(input logic [31:0] instr, input logic [3:0] st, input int n);
        ir   = instr;
        stat = st;
        for (int i = 0; i < n; i++) begin
            if (i == 2) begin
                ir = 32'hF0FF_FFFF;
                #1;
            end
            obs[i] = w_out;
            step();
        end
        obs[n] = w_out;
    endtask

    task automatic reset_to_fetch();
        rst_f = 1'b0;
        ir    = 32'h0;
        stat  = 4'h0;
        step();
        step();
        rst_f = 1'b1;
        step();
        step();
    endtask

    task automatic test_reset();
        rst_f = 1'b0;
        ir    = 32'h0;
        stat  = 4'h0;
        step();
        step();
        checks++;
        if (w_out !== 13'h1000) begin errors++; $display("FAIL reset_hold out=%h exp=%h", w_out, 13'h1000); end
        checks++;
        if (instr_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt cnt=%0d exp=0", instr_cnt); end
        rst_f = 1'b1;
        #1;
        checks++;
        if (w_out !== 13'h1000) begin errors++; $display("FAIL start0 out=%h exp=%h", w_out, 13'h1000); end
        step();
        checks++;
        if (w_out !== 13'h0000) begin errors++; $display("FAIL start1 out=%h exp=0", w_out); end
        step();
        checks++;
        if (w_out !== 13'h0900) begin errors++; $display("FAIL first_fetch out=%h exp=%h", w_out, 13'h0900); end
        checks++;
        if (instr_cnt !== 16'd0) begin errors++; $display("FAIL cnt_pre_retire cnt=%0d exp=0", instr_cnt); end
    endtask

    task automatic test_alu();
        logic [12:0] e [0:4];
        run(32'h2012_0005, 4'h0, 4);
        e = '{13'h0900, 13'h0000, 13'h0070, 13'h00E0, 13'h0900};
        for (int i = 0; i <= 4; i++) begin
            checks++;
            if (obs[i] !== e[i]) begin errors++; $display("FAIL alu_imm[%0d] out=%h exp=%h", i, obs[i], e[i]); end
        end
        checks++;
        if (instr_cnt !== 16'd1) begin errors++; $display("FAIL alu_imm_cnt cnt=%0d exp=1", instr_cnt); end
        run(32'h1123_4000, 4'h0, 4);
        e = '{13'h0900, 13'h0000, 13'h0030, 13'h00A0, 13'h0900};
        for (int i = 0; i <= 4; i++) begin
            checks++;
            if (obs[i] !== e[i]) begin errors++; $display("FAIL alu_rr[%0d] out=%h exp=%h", i, obs[i], e[i]); end
        end
        checks++;
        if (instr_cnt !== 16'd2) begin errors++; $display("FAIL alu_rr_cnt cnt=%0d exp=2", instr_cnt); end
    endtask

    task automatic test_ld_st();
        logic [12:0] e [0:5];
        run(32'h8120_0003, 4'h0, 5);
        e = '{13'h0900, 13'h0000, 13'h0040, 13'h0000, 13'h00C8, 13'h0900};
        for (int i = 0; i <= 5; i++) begin
            checks++;
            if (obs[i] !== e[i]) begin errors++; $display("FAIL ld[%0d] out=%h exp=%h", i, obs[i], e[i]); end
        end
        run(32'h9120_0003, 4'h0, 4);
        e = '{13'h0900, 13'h0000, 13'h0044, 13'h0006, 13'h0900, 13'h0000};
        for (int i = 0; i <= 4; i++) begin
            checks++;
            if (obs[i] !== e[i]) begin errors++; $display("FAIL st[%0d] out=%h exp=%h", i, obs[i], e[i]); end
        end
        checks++;
        if (instr_cnt !== 16'd4) begin errors++; $display("FAIL ld_st_cnt cnt=%0d exp=4", instr_cnt); end
    endtask

    task automatic test_branch();
        logic [31:0] iv [0:4];
        logic [3:0]  sv [0:4];
        logic [12:0] ex [0:4];
        iv = '{32'h4100_0010, 32'h4100_0010, 32'h7100_0010, 32'h6000_0000, 32'h3100_0000};
        sv = '{4'h1, 4'h0, 4'h0, 4'hF, 4'h1};
        ex = '{13'h0C00, 13'h0000, 13'h0E00, 13'h0C00, 13'h0000};
        for (int k = 0; k < 5; k++) begin
            run(iv[k], sv[k], 3);
            checks++;
            if (obs[1] !== 13'h0000) begin errors++; $display("FAIL br%0d_decode out=%h exp=0", k, obs[1]); end
            checks++;
            if (obs[2] !== ex[k]) begin errors++; $display("FAIL br%0d_exec out=%h exp=%h", k, obs[2], ex[k]); end
            checks++;
            if (obs[3] !== 13'h0900) begin errors++; $display("FAIL br%0d_fetch out=%h exp=%h", k, obs[3], 13'h0900); end
        end
        checks++;
        if (instr_cnt !== 16'd9) begin errors++; $display("FAIL br_cnt cnt=%0d exp=9", instr_cnt); end
    endtask

    task automatic test_reset_in_wb();
        ir   = 32'h2012_0005;
        stat = 4'h0;
        step();
        step();
        step();
        checks++;
        if (w_out !== 13'h00E0) begin errors++; $display("FAIL wb_before_rst out=%h exp=%h", w_out, 13'h00E0); end
        rst_f = 1'b0;
        #1;
        checks++;
        if (w_out !== 13'h0060) begin errors++; $display("FAIL wb_rst_gated out=%h exp=%h", w_out, 13'h0060); end
        step();
        checks++;
        if (w_out !== 13'h1000) begin errors++; $display("FAIL wb_rst_start0 out=%h exp=%h", w_out, 13'h1000); end
        checks++;
        if (instr_cnt !== 16'd0) begin errors++; $display("FAIL wb_rst_cnt cnt=%0d exp=0", instr_cnt); end
        rst_f = 1'b1;
        step();
        step();
        checks++;
        if (w_out !== 13'h0900) begin errors++; $display("FAIL wb_rst_refetch out=%h exp=%h", w_out, 13'h0900); end
    endtask

    task automatic test_halt();
        for (int k = 0; k < 3; k++) run(32'h0000_0000, 4'h0, 3);
        checks++;
        if (instr_cnt !== 16'd3) begin errors++; $display("FAIL nop_cnt cnt=%0d exp=3", instr_cnt); end
        run(32'hF000_0000, 4'h0, 2);
        checks++;
        if (obs[1] !== 13'h0000) begin errors++; $display("FAIL hlt_decode out=%h exp=0", obs[1]); end
        checks++;
        if (obs[2] !== 13'h0001) begin errors++; $display("FAIL hlt_enter out=%h exp=1", obs[2]); end
        checks++;
        if (instr_cnt !== 16'd4) begin errors++; $display("FAIL hlt_cnt cnt=%0d exp=4", instr_cnt); end
        for (int k = 0; k < 20; k++) begin
            ir   = $urandom;
            stat = 4'($urandom_range(0, 15));
            step();
            checks++;
            if (w_out !== 13'h0001 || instr_cnt !== 16'd4) begin
                errors++;
                $display("FAIL halt_hold[%0d] out=%h cnt=%0d exp out=1 cnt=4", k, w_out, instr_cnt);
            end
        end
    endtask

    task automatic test_wrap();
        reset_to_fetch();
        for (int k = 0; k < 5; k++) run(32'h0000_0000, 4'h0, 3);
        checks++;
        if (instr_cnt2 !== 2'd1) begin errors++; $display("FAIL wrap_cnt2 cnt=%0d exp=1", instr_cnt2); end
        checks++;
        if (instr_cnt !== 16'd5) begin errors++; $display("FAIL wrap_cnt16 cnt=%0d exp=5", instr_cnt); end
        checks++;
        if (w_out2 !== 13'h0900) begin errors++; $display("FAIL wrap_fetch2 out=%h exp=%h", w_out2, 13'h0900); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_ld_st();
        test_branch();
        test_reset_in_wb();
        test_halt();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
